// File: rtl/alu_arb_pkg.sv
// Shared widths, function codes and FSM state type for the ALU arbiter.
package alu_arb_pkg;

  localparam int WIDTH  = 16;
  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_AND = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_XOR = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_NOT = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_SHL = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_SHR = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational 16-bit ALU; results wrap at WIDTH and no carry is produced.
module ALU
  import alu_arb_pkg::*;
(
  input  logic [WIDTH-1:0]  Operand1,
  input  logic [WIDTH-1:0]  Operand2,
  input  logic [FUNC_W-1:0] FUNC,
  output logic [WIDTH-1:0]  Result,
  output logic              ZF
);

  always_comb begin
    Result = '0;
    case (FUNC)
      FUNC_ADD: Result = Operand1 + Operand2;
      FUNC_SUB: Result = Operand1 - Operand2;
      FUNC_AND: Result = Operand1 & Operand2;
      FUNC_OR:  Result = Operand1 | Operand2;
      FUNC_XOR: Result = Operand1 ^ Operand2;
      FUNC_NOT: Result = ~Operand1;
      FUNC_SHL: Result = Operand1 << 1;
      FUNC_SHR: Result = Operand1 >> 1;
      default:  Result = '0;
    endcase
  end

  assign ZF = (Result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences two requesters through the single shared ALU,
// returning each result on the owning requester's response channel.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_op1,
  input  logic [WIDTH-1:0]  req0_op2,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_op1,
  input  logic [WIDTH-1:0]  req1_op2,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zf,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zf,
  output logic              busy,
  output logic              owner
);

  state_t             state;
  logic               last_grant;
  logic               grant;
  logic [WIDTH-1:0]   op1_q;
  logic [WIDTH-1:0]   op2_q;
  logic [FUNC_W-1:0]  func_q;
  logic [WIDTH-1:0]   res_q;
  logic               zf_q;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zf;
  logic               owner_rsp_ready;

  // A lone requester always wins; under contention the one not served last goes next.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_grant;
    end
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && !grant && req0_valid;
  assign req1_ready = rst_n && (state == IDLE) &&  grant && req1_valid;

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_result = res_q;
  assign rsp0_zf     = zf_q;
  assign rsp1_result = res_q;
  assign rsp1_zf     = zf_q;

  ALU u_alu (
    .Operand1 (op1_q),
    .Operand2 (op2_q),
    .FUNC     (func_q),
    .Result   (alu_result),
    .ZF       (alu_zf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      func_q     <= '0;
      res_q      <= '0;
      zf_q       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            owner      <= grant;
            last_grant <= grant;
            op1_q      <= grant ? req1_op1  : req0_op1;
            op2_q      <= grant ? req1_op2  : req0_op2;
            func_q     <= grant ? req1_func : req0_func;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q      <= alu_result;
          zf_q       <= alu_zf;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed results, grant order and timing.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_op1, req0_op2, req1_op1, req1_op2;
  logic [FUNC_W-1:0] req0_func, req1_func;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0]  rsp0_result, rsp1_result;
  logic              rsp0_zf, rsp1_zf;
  logic              busy, owner;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit os0, os1;

  int acc_id[$];
  int acc_cyc[$];
  int rsp_id[$];
  int rsp_res[$];
  int rsp_zf[$];
  int rsp_cyc[$];

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_func(req1_func),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zf(rsp0_zf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zf(rsp1_zf),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU behaviour, 16-bit wrapping arithmetic.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [FUNC_W-1:0] f);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << 1;
      4'd7: return a >> 1;
      default: return '0;
    endcase
  endfunction

  function automatic bit pick(input bit v0, input bit v1, input bit last);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return !last;
  endfunction

  // Transaction model: m_age counts cycles since accept (0 = free, 1 = executing, 2 = responding).
  int              m_age;
  bit              m_owner, m_last;
  logic [WIDTH-1:0] m_res;
  bit              m_zf;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age <= 0; m_owner <= 1'b0; m_last <= 1'b1; m_res <= '0; m_zf <= 1'b0;
    end else if (m_age == 0) begin
      if (req0_valid || req1_valid) begin
        m_owner <= pick(req0_valid, req1_valid, m_last);
        m_last  <= pick(req0_valid, req1_valid, m_last);
        if (pick(req0_valid, req1_valid, m_last)) begin
          m_res <= alu_ref(req1_op1, req1_op2, req1_func);
          m_zf  <= (alu_ref(req1_op1, req1_op2, req1_func) == '0);
        end else begin
          m_res <= alu_ref(req0_op1, req0_op2, req0_func);
          m_zf  <= (alu_ref(req0_op1, req0_op2, req0_func) == '0);
        end
        m_age <= 1;
      end
    end else if (m_age == 1) begin
      m_age <= 2;
    end else if ((m_owner ? rsp1_ready : rsp0_ready)) begin
      m_age <= 0;
    end
  end

  // Per-cycle comparison against the model, plus handshake logging.
  always @(negedge clk) begin
    bit w;
    w = pick(req0_valid, req1_valid, m_last);
    checkOutput("req0_ready", req0_ready, rst_n && m_age == 0 && !w && req0_valid);
    checkOutput("req1_ready", req1_ready, rst_n && m_age == 0 &&  w && req1_valid);
    checkOutput("rsp0_valid", rsp0_valid, m_age == 2 && !m_owner);
    checkOutput("rsp1_valid", rsp1_valid, m_age == 2 &&  m_owner);
    checkOutput("busy", busy, m_age != 0);
    if (m_age != 0) checkOutput("owner", owner, m_owner);
    if (m_age == 2) begin
      checkOutput("rsp_result", m_owner ? rsp1_result : rsp0_result, m_res);
      checkOutput("rsp_zf", m_owner ? rsp1_zf : rsp0_zf, m_zf);
    end
    if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
    if (rsp0_valid && rsp0_ready) begin
      rsp_id.push_back(0); rsp_res.push_back(rsp0_result); rsp_zf.push_back(rsp0_zf); rsp_cyc.push_back(cyc);
    end
    if (rsp1_valid && rsp1_ready) begin
      rsp_id.push_back(1); rsp_res.push_back(rsp1_result); rsp_zf.push_back(rsp1_zf); rsp_cyc.push_back(cyc);
    end
  end

  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [FUNC_W-1:0] f, input bit one_shot);
    if (id == 0) begin
      req0_op1 = a; req0_op2 = b; req0_func = f; req0_valid = 1'b1; os0 = one_shot;
    end else begin
      req1_op1 = a; req1_op2 = b; req1_func = f; req1_valid = 1'b1; os1 = one_shot;
    end
  endtask

  // One clock; one-shot requesters withdraw right after their accept edge.
  task automatic stepCycle();
    bit a0, a1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (os0 && a0) req0_valid = 1'b0;
    if (os1 && a1) req1_valid = 1'b0;
  endtask

  task automatic waitRsp(input int count, input int limit, input string name);
    int n;
    n = 0;
    while (rsp_id.size() < count && n < limit) begin
      stepCycle();
      n++;
    end
    if (rsp_id.size() < count) checkOutput({name, "_timeout"}, rsp_id.size(), count);
  endtask

  task automatic checkRsp(input int idx, input int id, input int res, input int zf, input string name);
    if (idx < rsp_id.size()) begin
      checkOutput({name, "_id"}, rsp_id[idx], id);
      checkOutput({name, "_result"}, rsp_res[idx], res);
      checkOutput({name, "_zf"}, rsp_zf[idx], zf);
    end else begin
      checkOutput({name, "_missing"}, rsp_id.size(), idx + 1);
    end
  endtask

  initial begin
    int base, abase, n;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_func = '0;
    req1_op1 = '0; req1_op2 = '0; req1_func = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    os0 = 1'b1; os1 = 1'b1;

    // Reset values
    stepCycle(); stepCycle();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp0_valid", rsp0_valid, 0);
    checkOutput("reset_rsp1_valid", rsp1_valid, 0);
    checkOutput("reset_req0_ready", req0_ready, 0);
    rst_n = 1'b1;
    stepCycle();

    // Lone requester 0: ADD 5+10, latency 2
    applyStimulus(0, 16'd5, 16'd10, FUNC_ADD, 1'b1);
    waitRsp(1, 20, "add_5_10");
    checkRsp(0, 0, 15, 0, "add_5_10");
    if (acc_cyc.size() > 0 && rsp_cyc.size() > 0)
      checkOutput("latency", rsp_cyc[0] - acc_cyc[0], 2);
    stepCycle();

    // Requester 1: SUB 12-6 then SUB 6-6
    applyStimulus(1, 16'd12, 16'd6, FUNC_SUB, 1'b1);
    waitRsp(2, 20, "sub_12_6");
    checkRsp(1, 1, 6, 0, "sub_12_6");
    stepCycle();
    applyStimulus(1, 16'd6, 16'd6, FUNC_SUB, 1'b1);
    waitRsp(3, 20, "sub_6_6");
    checkRsp(2, 1, 0, 1, "sub_6_6");
    stepCycle();

    // Both valid through reset: requester 0 wins the first contention
    rst_n = 1'b0;
    applyStimulus(0, 16'd5, 16'd10, FUNC_ADD, 1'b1);
    applyStimulus(1, 16'd12, 16'd6, FUNC_SUB, 1'b1);
    stepCycle(); stepCycle();
    checkOutput("rst_req_ready0", req0_ready, 0);
    checkOutput("rst_req_ready1", req1_ready, 0);
    rst_n = 1'b1;
    base = rsp_id.size();
    waitRsp(base + 2, 30, "contend_first");
    checkRsp(base, 0, 15, 0, "contend_first0");
    checkRsp(base + 1, 1, 6, 0, "contend_first1");
    stepCycle();

    // Sustained contention: 6 accepts alternating, 3 cycles apart
    abase = acc_id.size();
    base = rsp_id.size();
    applyStimulus(0, 16'd1, 16'd2, FUNC_ADD, 1'b0);
    applyStimulus(1, 16'd9, 16'd4, FUNC_SUB, 1'b0);
    n = 0;
    while (acc_id.size() < abase + 6 && n < 40) begin stepCycle(); n++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc_id.size() < abase + 6) begin
      checkOutput("alt_timeout", acc_id.size(), abase + 6);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("alt_grant%0d", i), acc_id[abase + i], i % 2);
        if (i > 0) checkOutput($sformatf("alt_gap%0d", i), acc_cyc[abase + i] - acc_cyc[abase + i - 1], 3);
      end
    end
    waitRsp(base + 6, 20, "alt_rsp");
    checkRsp(base + 4, 0, 3, 0, "alt_rsp4");
    checkRsp(base + 5, 1, 5, 0, "alt_rsp5");
    stepCycle();

    // Response backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    base = rsp_id.size();
    applyStimulus(0, 16'd100, 16'd200, FUNC_ADD, 1'b1);
    applyStimulus(1, 16'd7, 16'd7, FUNC_SUB, 1'b1);
    n = 0;
    while (!rsp0_valid && n < 10) begin stepCycle(); n++; end
    checkOutput("bp_rsp0_valid", rsp0_valid, 1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("bp_result", rsp0_result, 300);
      checkOutput("bp_zf", rsp0_zf, 0);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_req1_ready", req1_ready, 0);
    end
    rsp0_ready = 1'b1;
    waitRsp(base + 2, 20, "bp_release");
    checkRsp(base, 0, 300, 0, "bp_release0");
    checkRsp(base + 1, 1, 0, 1, "bp_release1");
    stepCycle();

    // Reset during EXEC discards the operation; pending requester 1 goes first after
    base = rsp_id.size();
    abase = acc_id.size();
    applyStimulus(0, 16'd3, 16'd4, FUNC_ADD, 1'b1);
    applyStimulus(1, 16'd9, 16'd2, FUNC_SUB, 1'b1);
    n = 0;
    while (acc_id.size() == abase && n < 10) begin stepCycle(); n++; end
    checkOutput("abort_first_grant", (acc_id.size() > abase) ? acc_id[abase] : 9, 0);
    rst_n = 1'b0;
    stepCycle(); stepCycle();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rsp0_valid", rsp0_valid, 0);
    rst_n = 1'b1;
    waitRsp(base + 1, 20, "abort_next");
    checkRsp(base, 1, 7, 0, "abort_next");
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("abort_rsp_count", rsp_id.size(), base + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
